// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Used by divisor_seq and divisor_step.
package divisor_pkg;

    localparam int DIV_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divisor_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits.
module divisor_step
    import divisor_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N:0]   rem_in,
    input  logic         msb,
    input  logic [N-1:0] b,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] b_ext;

    // The partial remainder stays below B, so the extra top bit of
    // shifted is always 0; it is kept so the compare sees every bit.
    always_comb begin
        shifted = {rem_in, msb};
        b_ext   = {2'b00, b};
        q_bit   = (shifted >= b_ext);
        rem_out = q_bit ? (N+1)'(shifted - b_ext) : shifted[N:0];
    end

endmodule

// File: rtl/divisor_seq.sv
// Sequential N-bit restoring divider, one quotient bit per clock.
// Define DIVISOR_SEQ_SIGNED_EN for two's-complement operands and results.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero,
    output div_state_t   state
);

    localparam int CW = $clog2(N + 1);

    // Handshake: start is sampled only on an edge where busy=0; busy stays
    // high through CALC and DONE, and any start seen then is dropped.
    // done is a single-cycle strobe; Q/R/div_zero stay valid until the
    // next completion.

    div_state_t    state_q;
    div_state_t    state_d;
    logic [N:0]    rem_q;
    logic [N-1:0]  dvd_q;
    logic [N-1:0]  div_q;
    logic [CW-1:0] cnt_q;
    logic          last_iter;

    logic [N:0]    step_rem;
    logic          step_q;
    logic          rem_top_unused;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N-1:0]  q_mag;
    logic [N-1:0]  r_mag;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;

    divisor_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .msb     (dvd_q[N-1]),
        .b       (div_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign last_iter      = (cnt_q == CW'(1));
    assign q_mag          = {dvd_q[N-2:0], step_q};
    assign r_mag          = step_rem[N-1:0];
    assign rem_top_unused = step_rem[N];

`ifdef DIVISOR_SEQ_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;

    // Magnitudes feed the unsigned core; the most-negative value maps to
    // its own bit pattern, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = A[N-1] ? -A : A;
        b_mag = B[N-1] ? -B : B;
        q_fix = neg_q_q ? -q_mag : q_mag;
        r_fix = neg_r_q ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_q_q <= A[N-1] ^ B[N-1];
            neg_r_q <= A[N-1];
        end
    end
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_fix = q_mag;
        r_fix = r_mag;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        state   = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q <= '0;
                        dvd_q <= a_mag;
                        div_q <= b_mag;
                        cnt_q <= CW'(N);
                        // Divide by zero skips the iterations entirely.
                        if (B == '0) begin
                            Q        <= '1;
                            R        <= A;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= q_mag;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_iter) begin
                        Q        <= q_fix;
                        R        <= r_fix;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: randomized and directed divisions,
// checked against plain integer division.
module tb_divisor_seq;
    import divisor_pkg::*;

    localparam int N  = 8;
    localparam int RW = 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    div_state_t   st;

    divisor_seq #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .done     (done),
        .Q        (q),
        .R        (r),
        .div_zero (dz),
        .state    (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];

    // Reference: {div_zero, Q, R} from plain integer arithmetic.
    function automatic logic [RW-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] qq;
        logic [N-1:0] rr;
        if (y == '0) begin
            qq = '1;
            rr = x;
            return {1'b1, qq, rr};
        end
`ifdef DIVISOR_SEQ_SIGNED_EN
        begin
            int sx;
            int sy;
            sx = $signed(x);
            sy = $signed(y);
            qq = N'(sx / sy);
            rr = N'(sx % sy);
        end
`else
        qq = x / y;
        rr = x % y;
`endif
        return {1'b0, qq, rr};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every done pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        logic [RW-1:0] e;
        int            l;
        if (done) begin
            check("done_width", RW'(prev_done), RW'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got Q=%h R=%h dz=%b with no operation pending", q, r, dz);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result", {dz, q, r}, e);
                check("latency", RW'(cyc), RW'(l));
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1;
        lat_q.push_back(cyc + ((y == '0) ? 0 : N));
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", RW'(busy), RW'(0));
        check("reset_done", RW'(done), RW'(0));
        check("reset_out", {dz, q, r}, RW'(0));
        check("reset_state", RW'(st), RW'(IDLE));
        rst = 1'b0;

        // Directed: basic, back-to-back, divide by zero, recovery.
        issue(8'd100, 8'd5);
        issue(8'd44, 8'd7);
        issue(8'd202, 8'd9);
        issue(8'd255, 8'd0);
        issue(8'd10, 8'd3);
        issue(8'd0, 8'd1);
        issue(8'd255, 8'd1);
        issue(8'd1, 8'd255);

        // start and operand changes during CALC must not disturb the op.
        issue(8'd60, 8'd7);
        repeat (3) @(negedge clk);
        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);

        // Reset four cycles into CALC discards the op with no done pulse.
        issue(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midcalc_rst_busy", RW'(busy), RW'(0));
        check("midcalc_rst_out", {dz, q, r}, RW'(0));
        check("midcalc_rst_state", RW'(st), RW'(IDLE));
        repeat (12) @(negedge clk);
        issue(8'd9, 8'd2);

        // Signed corner cases (also valid unsigned operands).
        issue(8'hF9, 8'd2);
        issue(8'h80, 8'hFF);
        issue(8'd7, 8'hFE);
        issue(8'h80, 8'd0);

        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            x = N'($urandom_range(0, 255));
            y = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(0, 255));
            issue(x, y);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending results, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divisor_seq.md
# divisor_seq

Sequential, parametrised N-bit restoring divider that replaces the combinational 8-bit `divisor` in the calculator datapath. It is driven by the keypad input FSM on the DIV key. It accepts operands through a start/busy handshake and produces quotient, remainder and a divide-by-zero flag. It resolves one quotient bit per clock, trading latency for area and timing closure at wider N.

## Interface
- N, 8, operand/result width in bits (N ≥ 2)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only when busy=0
- A  input  N  dividend, captured on accepted start
- B  input  N  divisor, captured on accepted start
- busy  output  1  high while an operation is in flight (state ≠ IDLE)
- done  output  1  one-cycle pulse: Q/R/div_zero just became valid
- Q  output  N  quotient, registered
- R  output  N  remainder, registered
- div_zero  output  1  set with done when captured B = 0; held with Q/R

## Operation
- States: IDLE, CALC, DONE. Encoding is a package enum.
- IDLE:
  - start=1 → capture A, B, clear partial remainder, counter = N.
  - If B = 0, go to DONE; else go to CALC.
  - start=0 → stay in IDLE.
- CALC, each cycle:
  - rem = {rem[N-1:0], dividend MSB}.
  - Shift the dividend left.
  - If rem ≥ {0,B}: rem -= B and the new quotient bit is 1; else the bit is 0.
  - Decrement the counter. After the N-th iteration, go to DONE.
- DONE: drive done=1 for exactly one cycle, then return to IDLE unconditionally.
- Output updates:
  - Q/R/div_zero are written only on entry to DONE.
  - They hold until the next completion.
- Divide by zero: Q = all ones, R = A, div_zero = 1. No iterations are run.
- start while busy=1 (CALC or DONE) is ignored and is not queued.
- A/B changes after capture do not affect the operation in flight.
- Internal remainder is N+1 bits. Counter width is $clog2(N+1).
- No overflow is possible in unsigned mode.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, div_zero=0, state=IDLE, counter=0.
- Start accepted at edge k (B ≠ 0):
  - busy=1 from k.
  - CALC iterations occur on edges k+1 … k+N.
  - done=1 and valid outputs from edge k+N to edge k+N+1.
  - busy=0 after edge k+N+1.
  - Total latency is N+1 cycles from start to done.
- B = 0: done=1 in the cycle after the accepting edge. Total latency is 1 cycle.
- Earliest back-to-back start: the cycle in which done drops (busy=0). Throughput is one op per N+2 cycles.
- rst=1 at any edge, including mid-CALC or in DONE:
  - Return to IDLE with reset values next cycle.
  - The in-flight result is discarded and done is not pulsed.
- rst and start both high: rst wins.

## Configuration
- DIVISOR_SEQ_SIGNED_EN defined:
  - A, B, Q, R are two's complement.
  - Operands are converted to magnitude at capture and the unsigned core runs.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign (truncation toward zero).
  - Most-negative / -1 wraps to Q = most-negative, R = 0.
  - Divide by zero gives Q = -1 (all ones), R = A.
  - Latency is unchanged. Sign fix-up is done combinationally before the DONE register write.
- DIVISOR_SEQ_SIGNED_EN undefined: unsigned only, with no sign logic synthesised.

## Structure
- Shared package `divisor_pkg`:
  - `div_state_t` enum (IDLE, CALC, DONE).
  - Default width constant `DIV_N_DEFAULT = 8`.
- Sub-module `divisor_step` (combinational, parametrised N) implements one restoring iteration:
  - Inputs: rem_in, dividend MSB, B.
  - Outputs: rem_out, q_bit.
  - Instantiated once; the FSM and registers live in `divisor_seq`.

## Test plan
- N=8, A=100, B=5, start 1 cycle → done exactly 9 cycles later with Q=20, R=0, div_zero=0.
- A=44, B=7 then A=202, B=9, second start issued the cycle busy drops → Q=6, R=2 then Q=22, R=4. Each done is one cycle wide.
- A=255, B=0 → done 1 cycle after start, Q=255, R=255, div_zero=1. The next op, 10/3, clears div_zero: Q=3, R=1.
- start pulsed and A/B changed mid-CALC → ignored; result still matches the originally captured operands.
- rst asserted 4 cycles into CALC → next cycle busy=0, Q=0, R=0, no done pulse. A fresh 9/2 then yields Q=4, R=1.
- DIVISOR_SEQ_SIGNED_EN, N=8:
  - -7/2 → Q=0xFD (-3), R=0xFF (-1).
  - -128/-1 → Q=0x80, R=0.
  - 7/-2 → Q=0xFD, R=1.
